// File: rtl/iq_mag_synth_if.sv
// Sample bus for the IQ magnitude synthesiser.
// master drives samples and clear; slave returns results and counter.
interface iq_mag_synth_if #(
    parameter int DW    = 12,
    parameter int CNT_W = 16
);
    logic             valid_i;
    logic [1:0]       mode_i;
    logic [DW-1:0]    i_data_i;
    logic [DW-1:0]    q_data_i;
    logic             clr_i;
    logic             valid_o;
    logic [DW-1:0]    i_data_o;
    logic [DW-1:0]    q_data_o;
    logic             sat_o;
    logic [CNT_W-1:0] sat_cnt_o;

    modport master (
        output valid_i, mode_i, i_data_i, q_data_i, clr_i,
        input  valid_o, i_data_o, q_data_o, sat_o, sat_cnt_o
    );

    modport slave (
        input  valid_i, mode_i, i_data_i, q_data_i, clr_i,
        output valid_o, i_data_o, q_data_o, sat_o, sat_cnt_o
    );
endinterface

// File: rtl/iq_mag_synth.sv
// IQ magnitude synthesiser: pipelined floor(sqrt(I^2+Q^2)),
// gain with saturation, per-sample sign/mode mux, saturation counter.
module iq_mag_synth #(
    parameter int DW      = 12,
    parameter int GAIN_SH = 4,
    parameter int CNT_W   = 16
) (
    input logic         clk_i,
    input logic         rst_n,
    iq_mag_synth_if.slave bus
);
    localparam int MW = DW + GAIN_SH;
    localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};

    typedef struct packed {
        logic          v;
        logic [1:0]    mode;
        logic [DW-1:0] i;
        logic [DW-1:0] q;
    } sb_t;

    logic [2*DW-2:0] ie, qe;
    logic [2*DW-2:0] sq_i, sq_q;
    sb_t             sb1;

    assign ie = {{(DW-1){bus.i_data_i[DW-1]}}, bus.i_data_i};
    assign qe = {{(DW-1){bus.q_data_i[DW-1]}}, bus.q_data_i};

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sq_i <= '0;
            sq_q <= '0;
            sb1  <= '0;
        end else begin
            sq_i <= ie * ie;
            sq_q <= qe * qe;
            sb1  <= '{bus.valid_i, bus.mode_i, bus.i_data_i, bus.q_data_i};
        end
    end

    // Block k holds the state entering root step k; the radicand narrows by two bits per step.
    for (genvar k = 0; k < DW; k++) begin : g_sq
        localparam int NB = 2 * (DW - k);
        logic [NB-1:0] rad_q;
        logic [DW:0]   rem_q;
        logic [DW-1:0] root_q;
        sb_t           sb_q;
        logic [DW+2:0] acc;
        logic [DW+2:0] trial;
        logic          ge;

        assign acc   = {rem_q, rad_q[NB-1 -: 2]};
        assign trial = {1'b0, root_q, 2'b01};
        assign ge    = acc >= trial;

        if (k == 0) begin : g_ld
            always_ff @(posedge clk_i or negedge rst_n) begin
                if (!rst_n) begin
                    rad_q  <= '0;
                    rem_q  <= '0;
                    root_q <= '0;
                    sb_q   <= '0;
                end else begin
                    rad_q  <= {1'b0, sq_i} + {1'b0, sq_q};
                    rem_q  <= '0;
                    root_q <= '0;
                    sb_q   <= sb1;
                end
            end
        end else begin : g_ld
            always_ff @(posedge clk_i or negedge rst_n) begin
                if (!rst_n) begin
                    rad_q  <= '0;
                    rem_q  <= '0;
                    root_q <= '0;
                    sb_q   <= '0;
                end else begin
                    rad_q  <= g_sq[k-1].rad_q[NB-1:0];
                    rem_q  <= g_sq[k-1].ge
                            ? g_sq[k-1].acc[DW:0] - g_sq[k-1].trial[DW:0]
                            : g_sq[k-1].acc[DW:0];
                    root_q <= (g_sq[k-1].root_q << 1) | DW'(g_sq[k-1].ge);
                    sb_q   <= g_sq[k-1].sb_q;
                end
            end
        end
    end

    logic [DW-1:0] root_f;
    sb_t           sb_f;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            root_f <= '0;
            sb_f   <= '0;
        end else begin
            root_f <= (g_sq[DW-1].root_q << 1) | DW'(g_sq[DW-1].ge);
            sb_f   <= g_sq[DW-1].sb_q;
        end
    end

    logic [MW-1:0] m_w;
    logic          sat_c;
    logic [DW-1:0] mag, neg;
    logic [DW-1:0] i_n, q_n;
    logic          sat_n;

    assign m_w   = MW'(root_f) << GAIN_SH;
    assign sat_c = m_w > MW'(MAXV);
    assign mag   = sat_c ? MAXV : m_w[DW-1:0];
    assign neg   = -mag;

    always_comb begin
        i_n   = mag;
        q_n   = mag;
        sat_n = sat_c;
        unique case (sb_f.mode)
            2'd0: begin
                i_n = sb_f.i[DW-1] ? neg : mag;
                q_n = sb_f.q[DW-1] ? neg : mag;
            end
            2'd1: begin
                i_n = sb_f.q[DW-1] ? neg : mag;
                q_n = sb_f.q[DW-1] ? neg : mag;
            end
            2'd2: begin
                i_n = mag;
                q_n = mag;
            end
            2'd3: begin
                i_n   = sb_f.i;
                q_n   = sb_f.q;
                sat_n = 1'b0;
            end
        endcase
    end

    logic             valid_q, sat_q;
    logic [DW-1:0]    i_q, q_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            i_q     <= '0;
            q_q     <= '0;
        end else begin
            valid_q <= sb_f.v;
            sat_q   <= sb_f.v & sat_n;
            if (sb_f.v) begin
                i_q <= i_n;
                q_q <= q_n;
            end
        end
    end

    // Clear wins over a same-cycle increment; count sticks at all-ones.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.clr_i) begin
            cnt_q <= '0;
        end else if (sat_q && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.valid_o   = valid_q;
    assign bus.sat_o     = sat_q;
    assign bus.i_data_o  = i_q;
    assign bus.q_data_o  = q_q;
    assign bus.sat_cnt_o = cnt_q;
endmodule

// File: tb/tb_iq_mag_synth.sv
// Bench for iq_mag_synth: vector tables, model-driven random traffic,
// counter saturation/clear and mid-stream reset.
module tb_iq_mag_synth;
    localparam int DW  = 12;
    localparam int LAT = DW + 3;

    typedef struct {
        int i;
        int q;
        int mode;
        int ei;
        int eq;
        bit es;
    } vec_t;

    typedef struct {
        int ei;
        int eq;
        bit es;
        int t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_c4 = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q4[$];
    exp_t e0, e4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iq_mag_synth_if #(.DW(DW), .CNT_W(16)) b0 ();
    iq_mag_synth_if #(.DW(DW), .CNT_W(16)) b4 ();
    iq_mag_synth_if #(.DW(DW), .CNT_W(4))  bc ();

    iq_mag_synth #(.DW(DW), .GAIN_SH(0), .CNT_W(16)) u_g0 (
        .clk_i(clk), .rst_n(rst_n), .bus(b0)
    );
    iq_mag_synth #(.DW(DW), .GAIN_SH(4), .CNT_W(16)) u_g4 (
        .clk_i(clk), .rst_n(rst_n), .bus(b4)
    );
    iq_mag_synth #(.DW(DW), .GAIN_SH(0), .CNT_W(4)) u_c4 (
        .clk_i(clk), .rst_n(rst_c4), .bus(bc)
    );

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic exp_t model(input int i, input int q, input int m, input int gsh);
        exp_t r;
        int   s;
        int   rt;
        int   mg;
        s  = i * i + q * q;
        rt = 0;
        for (int b = DW - 1; b >= 0; b--)
            if ((rt + (1 << b)) * (rt + (1 << b)) <= s) rt += (1 << b);
        mg   = rt << gsh;
        r.es = mg > 2047;
        if (r.es) mg = 2047;
        r.t = 0;
        case (m)
            0: begin
                r.ei = (i < 0) ? -mg : mg;
                r.eq = (q < 0) ? -mg : mg;
            end
            1: begin
                r.ei = (q < 0) ? -mg : mg;
                r.eq = r.ei;
            end
            2: begin
                r.ei = mg;
                r.eq = mg;
            end
            default: begin
                r.ei = i;
                r.eq = q;
                r.es = 1'b0;
            end
        endcase
        return r;
    endfunction

    task automatic drv(input int d, input bit v, input int i, input int q,
                       input int m, input int ei, input int eq, input bit es);
        exp_t e;
        @(negedge clk);
        e = '{ei, eq, es, cyc};
        if (d == 0) begin
            b0.valid_i  = v;
            b0.i_data_i = DW'(i);
            b0.q_data_i = DW'(q);
            b0.mode_i   = 2'(m);
            if (v) q0.push_back(e);
        end else begin
            b4.valid_i  = v;
            b4.i_data_i = DW'(i);
            b4.q_data_i = DW'(q);
            b4.mode_i   = 2'(m);
            if (v) q4.push_back(e);
        end
    endtask

    task automatic idle(input int d, input int n);
        for (int k = 0; k < n; k++) drv(d, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && b0.valid_o) begin
            if (q0.size() == 0) begin
                chk("g0_unexpected_valid", 1, 0);
            end else begin
                e0 = q0.pop_front();
                chk("g0_i", int'($signed(b0.i_data_o)), e0.ei);
                chk("g0_q", int'($signed(b0.q_data_o)), e0.eq);
                chk("g0_sat", int'(b0.sat_o), int'(e0.es));
                chk("g0_latency", cyc - e0.t, LAT);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b4.valid_o) begin
            if (q4.size() == 0) begin
                chk("g4_unexpected_valid", 1, 0);
            end else begin
                e4 = q4.pop_front();
                chk("g4_i", int'($signed(b4.i_data_o)), e4.ei);
                chk("g4_q", int'($signed(b4.q_data_o)), e4.eq);
                chk("g4_sat", int'(b4.sat_o), int'(e4.es));
                chk("g4_latency", cyc - e4.t, LAT);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t t0[12];
        vec_t t4[7];
        exp_t r;
        int   ri, rq, rm, seen;
        bit   got;

        t0[0]  = '{3, 4, 0, 5, 5, 1'b0};
        t0[1]  = '{-3, 4, 0, -5, 5, 1'b0};
        t0[2]  = '{0, 0, 0, 0, 0, 1'b0};
        t0[3]  = '{3, -4, 1, -5, -5, 1'b0};
        t0[4]  = '{3, -4, 2, 5, 5, 1'b0};
        t0[5]  = '{-2048, -2048, 0, -2047, -2047, 1'b1};
        t0[6]  = '{3, -4, 3, 3, -4, 1'b0};
        t0[7]  = '{-2048, -2048, 3, -2048, -2048, 1'b0};
        t0[8]  = '{2047, 0, 0, 2047, 2047, 1'b0};
        t0[9]  = '{0, -1, 0, 1, -1, 1'b0};
        t0[10] = '{-5, -12, 2, 13, 13, 1'b0};
        t0[11] = '{6, 8, 1, 10, 10, 1'b0};

        t4[0] = '{100, 0, 2, 1600, 1600, 1'b0};
        t4[1] = '{200, 0, 2, 2047, 2047, 1'b1};
        t4[2] = '{127, 0, 2, 2032, 2032, 1'b0};
        t4[3] = '{128, 0, 2, 2047, 2047, 1'b1};
        t4[4] = '{-100, 0, 0, -1600, 1600, 1'b0};
        t4[5] = '{3, 4, 3, 3, 4, 1'b0};
        t4[6] = '{-7, -24, 1, -400, -400, 1'b0};

        b0.valid_i = 0; b0.mode_i = 0; b0.i_data_i = 0; b0.q_data_i = 0; b0.clr_i = 0;
        b4.valid_i = 0; b4.mode_i = 0; b4.i_data_i = 0; b4.q_data_i = 0; b4.clr_i = 0;
        bc.valid_i = 0; bc.mode_i = 0; bc.i_data_i = 0; bc.q_data_i = 0; bc.clr_i = 0;

        repeat (3) @(negedge clk);
        chk("rst_valid", int'(b0.valid_o), 0);
        chk("rst_i", int'(b0.i_data_o), 0);
        chk("rst_q", int'(b0.q_data_o), 0);
        chk("rst_sat", int'(b0.sat_o), 0);
        chk("rst_cnt", int'(b0.sat_cnt_o), 0);
        chk("rst_c4_cnt", int'(bc.sat_cnt_o), 0);
        rst_n  = 1'b1;
        rst_c4 = 1'b1;

        // back-to-back with a mode change every sample, then spaced out
        foreach (t0[k])
            drv(0, 1'b1, t0[k].i, t0[k].q, t0[k].mode, t0[k].ei, t0[k].eq, t0[k].es);
        foreach (t0[k]) begin
            drv(0, 1'b1, t0[k].i, t0[k].q, t0[k].mode, t0[k].ei, t0[k].eq, t0[k].es);
            idle(0, 1);
        end
        idle(0, LAT + 5);
        chk("g0_table_drained", q0.size(), 0);
        chk("g0_sat_cnt", int'(b0.sat_cnt_o), 2);

        foreach (t4[k]) begin
            drv(1, 1'b1, t4[k].i, t4[k].q, t4[k].mode, t4[k].ei, t4[k].eq, t4[k].es);
            idle(1, k % 3);
        end
        idle(1, LAT + 5);
        chk("g4_table_drained", q4.size(), 0);

        for (int k = 0; k < 80; k++) begin
            ri = int'($urandom_range(0, 4095)) - 2048;
            rq = int'($urandom_range(0, 4095)) - 2048;
            rm = (k < 40) ? int'($urandom_range(0, 3)) : 3;
            r  = model(ri, rq, rm, 0);
            drv(0, $urandom_range(0, 2) != 0, ri, rq, rm, r.ei, r.eq, r.es);
        end
        idle(0, LAT + 5);
        chk("g0_random_drained", q0.size(), 0);

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bc.valid_i  = 1'b1;
            bc.mode_i   = 2'd0;
            bc.i_data_i = 12'h800;
            bc.q_data_i = 12'h800;
        end
        @(negedge clk);
        bc.valid_i = 1'b0;
        repeat (LAT + 5) @(negedge clk);
        chk("c4_cnt_hold_max", int'(bc.sat_cnt_o), 15);
        chk("c4_idle_valid", int'(bc.valid_o), 0);
        chk("c4_idle_sat", int'(bc.sat_o), 0);
        chk("c4_hold_i", int'($signed(bc.i_data_o)), -2047);

        bc.valid_i = 1'b1;
        @(negedge clk);
        bc.valid_i = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 3 * LAT && !got; k++) begin
            @(negedge clk);
            if (bc.sat_o) got = 1'b1;
        end
        chk("c4_sat_seen", int'(got), 1);
        bc.clr_i = 1'b1;
        @(negedge clk);
        bc.clr_i = 1'b0;
        chk("c4_clr_wins", int'(bc.sat_cnt_o), 0);
        @(negedge clk);
        chk("c4_clr_stays", int'(bc.sat_cnt_o), 0);

        bc.valid_i = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        chk("c4_pre_valid", int'(bc.valid_o), 1);
        chk("c4_pre_cnt_nz", int'(bc.sat_cnt_o != 0), 1);
        #2;
        rst_c4 = 1'b0;
        #1;
        chk("c4_arst_valid", int'(bc.valid_o), 0);
        chk("c4_arst_i", int'(bc.i_data_o), 0);
        chk("c4_arst_q", int'(bc.q_data_o), 0);
        chk("c4_arst_sat", int'(bc.sat_o), 0);
        chk("c4_arst_cnt", int'(bc.sat_cnt_o), 0);
        bc.valid_i = 1'b0;
        @(negedge clk);
        rst_c4 = 1'b1;
        seen = 0;
        for (int k = 0; k < LAT + 5; k++) begin
            @(negedge clk);
            if (bc.valid_o) seen++;
        end
        chk("c4_no_stale_valid", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
